// File: rtl/cmd_frame_parser.sv
// Command frame parser: pulls bytes from an upstream FIFO and decodes HEADER, opcode, len, payload (+ checksum if CMD_PARSER_CHECKSUM_EN).
// Latency: cmd_vld rises the cycle after the last frame byte is accepted; FIFO reads are issued at most once every 2 cycles.
// Backpressure: while a decoded command waits for cmd_rdy no FIFO reads are issued and the command outputs hold stable.
module cmd_frame_parser #(
   parameter int         MAX_PAYLOAD_BYTES = 4,
   parameter logic [7:0] HEADER_BYTE       = 8'hAA,
   parameter int         TIMEOUT_CYCLES    = 50000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fifo_empty,
   output logic        fifo_r_en,
   input  logic [7:0]  fifo_data,
   input  logic        fifo_data_vld,
   output logic [7:0]  cmd_opcode,
   output logic [2:0]  cmd_len,
   output logic [31:0] cmd_payload,
   output logic        cmd_vld,
   input  logic        cmd_rdy,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   localparam logic [2:0] S_HDR = 3'd0;
   localparam logic [2:0] S_OP  = 3'd1;
   localparam logic [2:0] S_LEN = 3'd2;
   localparam logic [2:0] S_PAY = 3'd3;
   localparam logic [2:0] S_OUT = 3'd5;
`ifdef CMD_PARSER_CHECKSUM_EN
   localparam logic [2:0] S_CHK = 3'd4;
   // Where a frame goes after its last payload byte (or a zero length).
   localparam logic [2:0] S_END = S_CHK;
`else
   localparam logic [2:0] S_END = S_OUT;
`endif

   localparam int         TW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_BYTES);

   logic [2:0]    state;
   logic [2:0]    nxt_state;
   logic [TW-1:0] timer;
   logic [1:0]    idx;
   logic          in_frame;
   logic          timeout;
   logic          take;
   logic          err;
   logic          len_bad;
`ifdef CMD_PARSER_CHECKSUM_EN
   logic [7:0]    chk;
`endif

   assign in_frame = (state != S_HDR) && (state != S_OUT);
   assign timeout  = in_frame && (timer == T_LAST);
   assign len_bad  = (fifo_data > MAX_LEN);

   // Next-state decode; a timeout wins over a byte arriving in the same cycle, which is dropped.
   always_comb begin
      nxt_state = state;
      err       = 1'b0;
      take      = 1'b0;
      if (timeout) begin
         nxt_state = S_HDR;
         err       = 1'b1;
      end else if (state == S_OUT) begin
         if (cmd_rdy) nxt_state = S_HDR;
      end else if (fifo_data_vld) begin
         take = 1'b1;
         case (state)
            S_HDR: if (fifo_data == HEADER_BYTE) nxt_state = S_OP;
            S_OP:  nxt_state = S_LEN;
            S_LEN: begin
               if (len_bad) begin
                  nxt_state = S_HDR;
                  err       = 1'b1;
               end else if (fifo_data == 8'd0) begin
                  nxt_state = S_END;
               end else begin
                  nxt_state = S_PAY;
               end
            end
            S_PAY: if ({1'b0, idx} == cmd_len - 3'd1) nxt_state = S_END;
`ifdef CMD_PARSER_CHECKSUM_EN
            S_CHK: begin
               if (fifo_data == chk) begin
                  nxt_state = S_OUT;
               end else begin
                  nxt_state = S_HDR;
                  err       = 1'b1;
               end
            end
`endif
            default: nxt_state = S_HDR;
         endcase
      end
   end

   // Control: state, read pacing, command valid, error pulse/count and inter-byte timer.
   // fifo_r_en doubles as the outstanding-read flag: it is high for exactly the cycle the read is in flight,
   // so a new read can never be issued back to back, nor once the frame is about to park in S_OUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HDR;
         fifo_r_en <= 1'b0;
         cmd_vld   <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= 8'd0;
         timer     <= '0;
      end else begin
         state     <= nxt_state;
         fifo_r_en <= !fifo_empty && !fifo_r_en && (nxt_state != S_OUT) && (state != S_OUT);
         cmd_vld   <= (nxt_state == S_OUT);
         frame_err <= err;
         if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         if (in_frame && !fifo_data_vld && !timeout) timer <= timer + 1'b1;
         else                                        timer <= '0;
      end
   end

   // Datapath: capture opcode, length and payload bytes and fold them into the running checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_opcode  <= 8'd0;
         cmd_len     <= 3'd0;
         cmd_payload <= 32'd0;
         idx         <= 2'd0;
`ifdef CMD_PARSER_CHECKSUM_EN
         chk         <= 8'd0;
`endif
      end else if (take) begin
         case (state)
            S_OP: begin
               cmd_opcode  <= fifo_data;
               cmd_payload <= 32'd0;
`ifdef CMD_PARSER_CHECKSUM_EN
               chk         <= fifo_data;
`endif
            end
            S_LEN: begin
               if (!len_bad) begin
                  cmd_len <= fifo_data[2:0];
                  idx     <= 2'd0;
`ifdef CMD_PARSER_CHECKSUM_EN
                  chk     <= chk ^ fifo_data;
`endif
               end
            end
            S_PAY: begin
               cmd_payload[{idx, 3'b000} +: 8] <= fifo_data;
               idx <= idx + 2'd1;
`ifdef CMD_PARSER_CHECKSUM_EN
               chk <= chk ^ fifo_data;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: table of frames with hand-computed results plus timeout, backpressure,
// mid-frame reset and error-counter saturation sequences. Follows CMD_PARSER_CHECKSUM_EN for the frame format.
module tb_cmd_frame_parser;

   localparam int TMO = 100;

   logic        clk;
   logic        rst_n;
   logic        fifo_empty;
   logic        fifo_r_en;
   logic [7:0]  fifo_data;
   logic        fifo_data_vld;
   logic [7:0]  cmd_opcode;
   logic [2:0]  cmd_len;
   logic [31:0] cmd_payload;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        frame_err;
   logic [7:0]  err_cnt;

   cmd_frame_parser #(
      .MAX_PAYLOAD_BYTES(4),
      .HEADER_BYTE(8'hAA),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
      .fifo_data(fifo_data), .fifo_data_vld(fifo_data_vld), .cmd_opcode(cmd_opcode),
      .cmd_len(cmd_len), .cmd_payload(cmd_payload), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
      .frame_err(frame_err), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] b;       // frame bytes, first byte in [63:56]
      int          n;
      bit          add_chk;  // append computed checksum when checksumming is built in
      bit          ok;       // 1: expect a command, 0: expect frame_err
      logic [7:0]  op;
      logic [2:0]  len;
      logic [31:0] pay;
   } vec_t;

   logic [7:0] fq[$];
   int n_chk  = 0;
   int n_fail = 0;
   int exp_err = 0;
   int err_pulses = 0;
   int pace_bad = 0;

   // Byte FIFO model: a read request seen in a cycle returns data in the next cycle.
   initial begin
      bit rd;
      fifo_data_vld = 1'b0;
      fifo_data     = 8'h00;
      fifo_empty    = 1'b1;
      forever begin
         @(negedge clk);
         rd = fifo_r_en;
         @(posedge clk);
         #1;
         if (rd && fq.size() > 0) begin
            fifo_data     = fq.pop_front();
            fifo_data_vld = 1'b1;
         end else begin
            fifo_data_vld = 1'b0;
         end
         fifo_empty = (fq.size() == 0);
      end
   end

   // Observers: count frame_err pulses and flag read pacing / pulse width problems.
   initial begin
      bit prev_ren, prev_err;
      prev_ren = 1'b0;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (frame_err && !prev_err) err_pulses++;
         if (frame_err && prev_err) pace_bad++;
         if (fifo_r_en && (prev_ren || cmd_vld)) pace_bad++;
         prev_ren = fifo_r_en;
         prev_err = frame_err;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_hi(input string name, input bit want_err);
      bit seen = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (want_err ? frame_err : cmd_vld) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, {31'd0, seen}, 32'd1);
   endtask

   function automatic logic [7:0] xsum(input logic [7:0] op, input logic [2:0] len, input logic [31:0] pay);
      return op ^ {5'd0, len} ^ pay[7:0] ^ pay[15:8] ^ pay[23:16] ^ pay[31:24];
   endfunction

   task automatic push_vec(input vec_t v);
      logic [63:0] bb;
      bb = v.b;
      for (int j = 0; j < v.n; j++) fq.push_back(bb[63 - 8*j -: 8]);
`ifdef CMD_PARSER_CHECKSUM_EN
      if (v.add_chk) fq.push_back(xsum(v.op, v.len, v.pay));
`endif
   endtask

   task automatic release_cmd(input string name);
      cmd_rdy = 1'b1;
      @(negedge clk);
      cmd_rdy = 1'b0;
      check({name, " vld_drop"}, {31'd0, cmd_vld}, 32'd0);
   endtask

   task automatic apply_vec(input string name, input vec_t v);
      push_vec(v);
      if (v.ok) begin
         wait_hi({name, " cmd_vld"}, 1'b0);
         check({name, " opcode"},  {24'd0, cmd_opcode}, {24'd0, v.op});
         check({name, " len"},     {29'd0, cmd_len},    {29'd0, v.len});
         check({name, " payload"}, cmd_payload,         v.pay);
         check({name, " err_cnt"}, {24'd0, err_cnt},    exp_err);
         release_cmd(name);
      end else begin
         wait_hi({name, " frame_err"}, 1'b1);
         exp_err++;
         check({name, " err_cnt"}, {24'd0, err_cnt}, exp_err);
         check({name, " no_vld"},  {31'd0, cmd_vld}, 32'd0);
      end
   endtask

   initial begin
      vec_t vt[$];
      logic [7:0]  s_op;
      logic [2:0]  s_len;
      logic [31:0] s_pay;
      int bad, dly, p0;
      bit got;

      vt.push_back('{64'h55AA0700_00000000, 4, 1'b1, 1'b1, 8'h07, 3'd0, 32'h00000000});
      vt.push_back('{64'hAA010210_20000000, 5, 1'b1, 1'b1, 8'h01, 3'd2, 32'h00002010});
      vt.push_back('{64'hAA010500_00000000, 3, 1'b0, 1'b0, 8'h00, 3'd0, 32'h00000000});
      vt.push_back('{64'hAA5A01FF_00000000, 4, 1'b1, 1'b1, 8'h5A, 3'd1, 32'h000000FF});
      vt.push_back('{64'hAA3C0411_22334400, 7, 1'b1, 1'b1, 8'h3C, 3'd4, 32'h44332211});
`ifdef CMD_PARSER_CHECKSUM_EN
      vt.push_back('{64'hAA0101FF_00000000, 5, 1'b0, 1'b0, 8'h00, 3'd0, 32'h00000000});
`endif
      vt.push_back('{64'h1234AA99_03010203, 8, 1'b1, 1'b1, 8'h99, 3'd3, 32'h00030201});

      // Reset state, with a byte waiting so a stray read during reset would show.
      rst_n   = 1'b0;
      cmd_rdy = 1'b0;
      fq.push_back(8'h55);
      repeat (3) @(negedge clk);
      check("rst fifo_r_en",   {31'd0, fifo_r_en}, 32'd0);
      check("rst cmd_vld",     {31'd0, cmd_vld},   32'd0);
      check("rst frame_err",   {31'd0, frame_err}, 32'd0);
      check("rst err_cnt",     {24'd0, err_cnt},   32'd0);
      check("rst cmd_opcode",  {24'd0, cmd_opcode}, 32'd0);
      check("rst cmd_len",     {29'd0, cmd_len},   32'd0);
      check("rst cmd_payload", cmd_payload,        32'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("junk discarded", {24'd0, err_cnt}, 32'd0);

      foreach (vt[i]) apply_vec($sformatf("vec%0d", i), vt[i]);

      // Timeout: header and opcode, then nothing.
      fq.push_back(8'hAA);
      fq.push_back(8'h01);
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (fifo_data_vld && fifo_data == 8'h01) begin
            got = 1'b1;
            break;
         end
      end
      check("tmo opcode seen", {31'd0, got}, 32'd1);
      dly = -1;
      for (int k = 1; k < 300; k++) begin
         @(negedge clk);
         if (frame_err) begin
            dly = k - 1;
            break;
         end
      end
      exp_err++;
      check("tmo delay", dly, TMO);
      check("tmo err_cnt", {24'd0, err_cnt}, exp_err);

      // Backpressure: two frames queued, first one held for 20 cycles.
      push_vec('{64'hAA21015A_00000000, 4, 1'b1, 1'b1, 8'h21, 3'd1, 32'h0000005A});
      push_vec('{64'hAA220201_02000000, 5, 1'b1, 1'b1, 8'h22, 3'd2, 32'h00000201});
      wait_hi("bp first vld", 1'b0);
      check("bp first op",  {24'd0, cmd_opcode}, 32'h21);
      check("bp first pay", cmd_payload,         32'h5A);
      s_op = cmd_opcode; s_len = cmd_len; s_pay = cmd_payload;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_r_en || !cmd_vld || cmd_opcode !== s_op || cmd_len !== s_len || cmd_payload !== s_pay) bad++;
      end
      check("bp hold", bad, 0);
      release_cmd("bp first");
      wait_hi("bp second vld", 1'b0);
      check("bp second op",  {24'd0, cmd_opcode}, 32'h22);
      check("bp second len", {29'd0, cmd_len},    32'd2);
      check("bp second pay", cmd_payload,         32'h201);
      release_cmd("bp second");
      check("read pacing", pace_bad, 0);

      // Reset in the middle of a frame.
      fq.push_back(8'hAA); fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h10);
      repeat (5) @(negedge clk);
      p0 = err_pulses;
      rst_n = 1'b0;
      fq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_err = 0;
      repeat (TMO + 20) @(negedge clk);
      check("midrst no err pulse", err_pulses - p0, 0);
      check("midrst err_cnt", {24'd0, err_cnt}, 32'd0);
      apply_vec("after midrst", vt[1]);

      // Error counter saturation with 260 length errors.
      p0 = err_pulses;
      for (int i = 0; i < 260; i++) begin
         fq.push_back(8'hAA); fq.push_back(8'h01); fq.push_back(8'h05);
      end
      for (int k = 0; k < 4000 && fq.size() > 0; k++) @(negedge clk);
      repeat (10) @(negedge clk);
      check("sat pulses", err_pulses - p0, 260);
      check("sat err_cnt", {24'd0, err_cnt}, 32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
